// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared state encoding and serial line levels for piso_tx.
// Macro PISO_TX_PARITY_EN adds the PAR state to the enumeration.
package piso_tx_pkg;
`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    PAR   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif
  localparam logic SO_IDLE  = 1'b1;
  localparam logic SO_START = 1'b0;
  localparam logic SO_STOP  = 1'b1;
endpackage

// File: rtl/piso_bit_timer.sv
// piso_bit_timer: DIV-cycle down-counter producing a tick on the last cycle of each bit.
// Ports: i_clk (updates on falling edge), i_rst (async clear), i_restart (reload on a frame load),
//        o_tick (high during the final cycle of the current bit period).
module piso_bit_timer #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam logic [7:0] RELOAD = 8'(DIV - 1);
  logic [7:0] r_cnt;
  assign o_tick = (r_cnt == 8'd0);
  always_ff @(negedge i_clk or posedge i_rst)
    if (i_rst)
      r_cnt <= 8'd0;
    else
      r_cnt <= (i_restart || o_tick) ? RELOAD : r_cnt - 8'd1;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out frame transmitter (start, WIDTH data bits LSB first, stop).
// Ports: C clock (falling edge), RE async active-high reset, D parallel word, LD load strobe,
//        SO registered serial line (idles high), BUSY frame in progress, DONE one-cycle end-of-frame pulse.
// Macro PISO_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             C,
  input  logic             RE,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_shift, w_shift_n;
  logic [3:0]       r_bit, w_bit_n;
  logic             r_so, w_so_n;
  logic             r_done, w_done_n;
  logic             w_tick, w_load;
`ifdef PISO_TX_PARITY_EN
  logic             r_par;
`endif
  assign w_load = (r_state == IDLE) && LD;
  assign SO     = r_so;
  assign DONE   = r_done;
  assign BUSY   = (r_state != IDLE);
  piso_bit_timer #(.DIV(DIV)) u_timer (
    .i_clk    (C),
    .i_rst    (RE),
    .i_restart(w_load),
    .o_tick   (w_tick)
  );
  // The shift register always holds the bits still to be sent; each bit is
  // moved into r_so as it starts so SO never depends on D or LD combinationally.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit;
    w_so_n    = r_so;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: if (LD) begin
        w_state_n = START;
        w_shift_n = D;
        w_bit_n   = 4'd0;
        w_so_n    = SO_START;
      end
      START: if (w_tick) begin
        w_state_n = DATA;
        w_so_n    = r_shift[0];
        w_shift_n = r_shift >> 1;
      end
      DATA: if (w_tick) begin
        if (r_bit == 4'(WIDTH - 1)) begin
`ifdef PISO_TX_PARITY_EN
          w_state_n = PAR;
          w_so_n    = r_par;
`else
          w_state_n = STOP;
          w_so_n    = SO_STOP;
`endif
        end else begin
          w_bit_n   = r_bit + 4'd1;
          w_so_n    = r_shift[0];
          w_shift_n = r_shift >> 1;
        end
      end
`ifdef PISO_TX_PARITY_EN
      PAR: if (w_tick) begin
        w_state_n = STOP;
        w_so_n    = SO_STOP;
      end
`endif
      STOP: if (w_tick) begin
        w_state_n = IDLE;
        w_so_n    = SO_IDLE;
        w_done_n  = 1'b1;
      end
      default: begin
        w_state_n = IDLE;
        w_so_n    = SO_IDLE;
      end
    endcase
  end
  always_ff @(negedge C or posedge RE)
    if (RE) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= 4'd0;
      r_so    <= SO_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bit   <= w_bit_n;
      r_so    <= w_so_n;
      r_done  <= w_done_n;
    end
`ifdef PISO_TX_PARITY_EN
  // Parity is taken from the whole word at load time, before shifting consumes it.
  always_ff @(negedge C or posedge RE)
    if (RE)
      r_par <= 1'b0;
    else if (w_load)
      r_par <= ^D;
`endif
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx (DIV=1 and DIV=4 instances, WIDTH=8).
module tb_piso_tx;
`ifdef PISO_TX_PARITY_EN
  localparam int NP = 1;
`else
  localparam int NP = 0;
`endif
  localparam int NB = 10 + NP;
  logic       c, re;
  logic [7:0] d1, d4;
  logic       ld1, ld4;
  logic       so1, busy1, done1, so4, busy4, done4;
  int         tests, fails;

  piso_tx #(.WIDTH(8), .DIV(1)) u1 (
    .C(c), .RE(re), .D(d1), .LD(ld1), .SO(so1), .BUSY(busy1), .DONE(done1)
  );
  piso_tx #(.WIDTH(8), .DIV(4)) u4 (
    .C(c), .RE(re), .D(d4), .LD(ld4), .SO(so4), .BUSY(busy4), .DONE(done4)
  );

  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset;
    #2 re = 1'b1;
    ld1 = 1'b1;
    d1  = 8'h00;
    repeat (3) @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b100) begin
      fails++;
      $display("FAIL reset_u1 got %b exp 100", {so1, busy1, done1});
    end
    tests++;
    if ({so4, busy4, done4} !== 3'b100) begin
      fails++;
      $display("FAIL reset_u4 got %b exp 100", {so4, busy4, done4});
    end
    re = 1'b0;
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b010) begin
      fails++;
      $display("FAIL first_load_after_reset got %b exp 010", {so1, busy1, done1});
    end
    ld1 = 1'b0;
    repeat (11 + NP) @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b100) begin
      fails++;
      $display("FAIL idle_after_first_frame got %b exp 100", {so1, busy1, done1});
    end
  endtask

  task automatic test_single_frame;
    logic [10:0] e;
`ifdef PISO_TX_PARITY_EN
    e = 11'b10101001010;
`else
    e = 11'b01101001010;
`endif
    @(posedge c);
    d1  = 8'hA5;
    ld1 = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(posedge c);
      ld1 = 1'b0;
      tests++;
      if ({so1, busy1, done1} !== {e[k], 2'b10}) begin
        fails++;
        $display("FAIL single_frame k=%0d got %b exp %b", k, {so1, busy1, done1}, {e[k], 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b101) begin
      fails++;
      $display("FAIL single_frame_done got %b exp 101", {so1, busy1, done1});
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b100) begin
      fails++;
      $display("FAIL single_frame_done_pulse got %b exp 100", {so1, busy1, done1});
    end
  endtask

  task automatic test_bit_timing;
    logic x;
    @(posedge c);
    d4  = 8'h01;
    ld4 = 1'b1;
    for (int k = 0; k < 40 + 4 * NP; k++) begin
      @(posedge c);
      ld4 = 1'b0;
      x = (k < 4) ? 1'b0 : (k < 8) ? 1'b1 : (k < 36) ? 1'b0 : 1'b1;
      tests++;
      if ({so4, busy4, done4} !== {x, 2'b10}) begin
        fails++;
        $display("FAIL bit_timing k=%0d got %b exp %b", k, {so4, busy4, done4}, {x, 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so4, busy4, done4} !== 3'b101) begin
      fails++;
      $display("FAIL bit_timing_done got %b exp 101", {so4, busy4, done4});
    end
    @(posedge c);
    tests++;
    if ({so4, busy4, done4} !== 3'b100) begin
      fails++;
      $display("FAIL bit_timing_idle got %b exp 100", {so4, busy4, done4});
    end
  endtask

  task automatic test_load_while_busy;
    logic x;
    @(posedge c);
    d1  = 8'h00;
    ld1 = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(posedge c);
      ld1 = (k >= 2) && (k < 5);
      d1  = (k >= 2) ? 8'hFF : 8'h00;
      x = (k < NB - 1) ? 1'b0 : 1'b1;
      tests++;
      if ({so1, busy1, done1} !== {x, 2'b10}) begin
        fails++;
        $display("FAIL load_while_busy k=%0d got %b exp %b", k, {so1, busy1, done1}, {x, 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b101) begin
      fails++;
      $display("FAIL load_while_busy_done got %b exp 101", {so1, busy1, done1});
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b100) begin
      fails++;
      $display("FAIL load_while_busy_idle got %b exp 100", {so1, busy1, done1});
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] ea, eb;
`ifdef PISO_TX_PARITY_EN
    ea = 11'b10001111000;
    eb = 11'b10100000010;
`else
    ea = 11'b01001111000;
    eb = 11'b01100000010;
`endif
    @(posedge c);
    d1  = 8'h3C;
    ld1 = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(posedge c);
      d1 = 8'h81;
      tests++;
      if ({so1, busy1, done1} !== {ea[k], 2'b10}) begin
        fails++;
        $display("FAIL back_to_back_a k=%0d got %b exp %b", k, {so1, busy1, done1}, {ea[k], 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b101) begin
      fails++;
      $display("FAIL back_to_back_done_a got %b exp 101", {so1, busy1, done1});
    end
    for (int k = 0; k < NB; k++) begin
      @(posedge c);
      ld1 = 1'b0;
      tests++;
      if ({so1, busy1, done1} !== {eb[k], 2'b10}) begin
        fails++;
        $display("FAIL back_to_back_b k=%0d got %b exp %b", k, {so1, busy1, done1}, {eb[k], 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b101) begin
      fails++;
      $display("FAIL back_to_back_done_b got %b exp 101", {so1, busy1, done1});
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b100) begin
      fails++;
      $display("FAIL back_to_back_idle got %b exp 100", {so1, busy1, done1});
    end
  endtask

  task automatic test_reset_mid_frame;
    logic seen;
    logic x;
    @(posedge c);
    d4  = 8'hA5;
    ld4 = 1'b1;
    @(posedge c);
    ld4 = 1'b0;
    repeat (21) @(posedge c);
    tests++;
    if ({so4, busy4, done4} !== 3'b010) begin
      fails++;
      $display("FAIL mid_frame_bit4 got %b exp 010", {so4, busy4, done4});
    end
    #1 re = 1'b1;
    #1;
    tests++;
    if ({so4, busy4, done4} !== 3'b100) begin
      fails++;
      $display("FAIL mid_frame_abort got %b exp 100", {so4, busy4, done4});
    end
    @(posedge c);
    re = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge c);
      seen = seen | done4 | busy4;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL mid_frame_no_done got %b exp 0", seen);
    end
    d4  = 8'h80;
    ld4 = 1'b1;
    for (int k = 0; k < 40 + 4 * NP; k++) begin
      @(posedge c);
      ld4 = 1'b0;
      x = (k < 32) ? 1'b0 : 1'b1;
      tests++;
      if ({so4, busy4, done4} !== {x, 2'b10}) begin
        fails++;
        $display("FAIL clean_frame k=%0d got %b exp %b", k, {so4, busy4, done4}, {x, 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so4, busy4, done4} !== 3'b101) begin
      fails++;
      $display("FAIL clean_frame_done got %b exp 101", {so4, busy4, done4});
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity;
    logic [10:0] e;
    e = 11'b11000001110;
    @(posedge c);
    d1  = 8'h07;
    ld1 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(posedge c);
      ld1 = 1'b0;
      tests++;
      if ({so1, busy1, done1} !== {e[k], 2'b10}) begin
        fails++;
        $display("FAIL parity k=%0d got %b exp %b", k, {so1, busy1, done1}, {e[k], 2'b10});
      end
    end
    @(posedge c);
    tests++;
    if ({so1, busy1, done1} !== 3'b101) begin
      fails++;
      $display("FAIL parity_done got %b exp 101", {so1, busy1, done1});
    end
  endtask
`endif

  initial begin
    c     = 1'b0;
    re    = 1'b0;
    d1    = 8'h00;
    d4    = 8'h00;
    ld1   = 1'b0;
    ld4   = 1'b0;
    tests = 0;
    fails = 0;
    test_reset;
    test_single_frame;
    test_bit_timing;
    test_load_while_busy;
    test_back_to_back;
    test_reset_mid_frame;
`ifdef PISO_TX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, sets data bits per frame (legal range 1..16).
REQ-002 Parameter DIV, default 4, sets clock cycles per serial bit (legal range 1..255).
REQ-003 Port C, input, 1 bit: the one clock; all state updates on the falling edge of C.
REQ-004 Port RE, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port D, input, WIDTH bits: parallel data word to transmit.
REQ-006 Port LD, input, 1 bit: load strobe; sampled on the falling edge of C.
REQ-007 Port SO, output, 1 bit: serial line out; idles high.
REQ-008 Port BUSY, output, 1 bit: high while a frame is in progress.
REQ-009 Port DONE, output, 1 bit: one-cycle pulse marking the end of a frame.

Function
REQ-010 States SHALL be IDLE, START, DATA, PAR (only with PARITY_EN) and STOP.
REQ-011 In IDLE with LD=1 at a falling edge, the block SHALL capture D into a shift register, enter START and assert BUSY at that edge.
REQ-012 LD SHALL be ignored whenever BUSY=1; the captured word SHALL not change mid-frame.
REQ-013 Each bit SHALL be held on SO for exactly DIV cycles, counted by a bit timer that restarts at every state or bit change.
REQ-014 START drives SO=0; DATA drives data LSB first, WIDTH bits; STOP drives SO=1.
REQ-015 Transitions: START->DATA after DIV cycles; DATA->PAR (or STOP) after the WIDTH-th bit; PAR->STOP after DIV cycles; STOP->IDLE after DIV cycles.
REQ-016 On the STOP->IDLE edge, BUSY SHALL fall and DONE SHALL be 1 for exactly one cycle.
REQ-017 LD=1 in the cycle where DONE=1 SHALL be accepted at the next edge; no extra idle bit is inserted.
REQ-018 Total frame length SHALL be (WIDTH+2[+1 with parity])*DIV cycles from the LD-accepting edge to the DONE edge.
REQ-019 SO SHALL be a registered output with no combinational path from D or LD.

Reset
REQ-020 RE=1 SHALL force IDLE, SO=1, BUSY=0, DONE=0, and clear the bit timer and bit counter, independent of C.
REQ-021 RE asserted mid-frame SHALL abort the frame immediately, with no DONE pulse.
REQ-022 LD SHALL be ignored while RE=1; the first accepted load is at the first falling edge after RE falls.

Configuration
REQ-023 Macro PISO_TX_PARITY_EN, when defined, SHALL add the PAR state, driving the even-parity bit (XOR of all WIDTH data bits) for DIV cycles between DATA and STOP.
REQ-024 Without PISO_TX_PARITY_EN, there SHALL be no PAR state and no parity logic, and DATA SHALL go directly to STOP.

Structure
REQ-025 Package piso_tx_pkg SHALL hold the state enumeration type and the SO idle/start/stop level constants.
REQ-026 Bit timing SHALL be implemented in one sub-module, piso_bit_timer: a DIV-cycle down-counter that outputs a one-cycle tick, clears on RE, and restarts on a load.

Verification
REQ-027 Single frame: WIDTH=8, DIV=1, D=0xA5, LD pulsed -> SO sequence 0,1,0,1,0,0,1,0,1,1; DONE at cycle 10.
REQ-028 Bit timing: DIV=4, D=0x01 -> SO=0 for 4 cycles, then 1 for 4 cycles, then 0 for 28 cycles, then 1 for 4 cycles; BUSY high for 40 cycles.
REQ-029 Load while busy: LD=1 with D=0xFF in the 3rd bit of a 0x00 frame -> data bits all 0, frame unchanged.
REQ-030 Back-to-back: LD held high with D=0x3C then 0x81 -> second START begins at the edge after DONE, SO stays 0 for the start bit, no idle gap.
REQ-031 Reset mid-frame: RE raised during DATA bit 4 -> SO=1 and BUSY=0 immediately, no DONE, and the next LD gives a full clean frame.
REQ-032 Parity (with PISO_TX_PARITY_EN): D=0x07, DIV=1 -> parity bit 1 at cycle 9, STOP at cycle 10, DONE at cycle 11.
